// File: rtl/sparse_act_encoder.sv
// Compresses a dense activation row stream into a per-row zero-flag word plus
// non-zero values packed PACK per FM word, on the mem_controller write protocol.
module sparse_act_encoder #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned PACK          = 3,
   parameter int unsigned ROW_LEN       = 16,
   parameter int unsigned ROW_CNT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [ROW_CNT_WIDTH-1:0]      num_rows,
   input  logic                          in_valid,
   input  logic [DATA_WIDTH-1:0]         in_data,
   output logic                          in_ready,
   output logic                          wr_req_act_flag,
   output logic [ROW_LEN-1:0]            wr_data_act_flag,
   output logic                          wr_req_act,
   output logic [PACK*DATA_WIDTH-1:0]    wr_data_act,
   output logic [$clog2(ROW_LEN+1)-1:0]  row_val_num,
   output logic                          busy,
   output logic                          done
);

   localparam int unsigned FM_W   = PACK * DATA_WIDTH;
   localparam int unsigned IDX_W  = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
   localparam int unsigned LANE_W = $clog2(PACK + 1);
   localparam int unsigned CNT_W  = $clog2(ROW_LEN + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e                   state_q, state_d;
   logic [ROW_CNT_WIDTH-1:0] rows_q, rows_d;
   logic [ROW_CNT_WIDTH-1:0] row_cnt_q, row_cnt_d;
   logic [IDX_W-1:0]         elem_idx_q, elem_idx_d;
   logic [LANE_W-1:0]        lane_cnt_q, lane_cnt_d;
   logic [FM_W-1:0]          word_q, word_d;
   logic [ROW_LEN-1:0]       flags_q, flags_d;
   logic [CNT_W-1:0]         nz_cnt_q, nz_cnt_d;

   logic                     wr_req_act_q, wr_req_act_d;
   logic [FM_W-1:0]          wr_data_act_q, wr_data_act_d;
   logic                     wr_req_flag_q, wr_req_flag_d;
   logic [ROW_LEN-1:0]       wr_data_flag_q, wr_data_flag_d;
   logic [CNT_W-1:0]         row_val_num_q, row_val_num_d;

   logic                     nz;
   logic                     last_elem;
   logic                     emit;
   logic [LANE_W-1:0]        lane_nxt;
   logic [FM_W-1:0]          word_ins;
   logic [ROW_LEN-1:0]       flags_nxt;
   logic [CNT_W-1:0]         nz_nxt;
   logic [ROW_CNT_WIDTH-1:0] row_cnt_inc;

   // Datapath view of the current element as if it were accepted this cycle.
   always_comb begin
      nz        = |in_data;
      last_elem = (elem_idx_q == IDX_W'(ROW_LEN - 1));
      lane_nxt  = lane_cnt_q + LANE_W'(nz);
      flags_nxt = {flags_q[ROW_LEN-2:0], nz};
      nz_nxt    = nz_cnt_q + CNT_W'(nz);
      row_cnt_inc = row_cnt_q + ROW_CNT_WIDTH'(1);
      word_ins  = word_q;
      for (int unsigned l = 0; l < PACK; l++) begin
         if (nz && (lane_cnt_q == LANE_W'(l)))
            word_ins[(PACK-1-l)*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
      emit = (lane_nxt == LANE_W'(PACK)) || (last_elem && (lane_nxt != '0));
   end

   always_comb begin
      state_d        = state_q;
      rows_d         = rows_q;
      row_cnt_d      = row_cnt_q;
      elem_idx_d     = elem_idx_q;
      lane_cnt_d     = lane_cnt_q;
      word_d         = word_q;
      flags_d        = flags_q;
      nz_cnt_d       = nz_cnt_q;
      wr_req_act_d   = 1'b0;
      wr_data_act_d  = wr_data_act_q;
      wr_req_flag_d  = 1'b0;
      wr_data_flag_d = wr_data_flag_q;
      row_val_num_d  = row_val_num_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (num_rows != '0) begin
                  state_d    = ST_RUN;
                  rows_d     = num_rows;
                  row_cnt_d  = '0;
                  elem_idx_d = '0;
                  lane_cnt_d = '0;
                  word_d     = '0;
                  flags_d    = '0;
                  nz_cnt_d   = '0;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RUN: begin
            if (in_valid) begin
               flags_d  = flags_nxt;
               nz_cnt_d = nz_nxt;
               if (emit) begin
                  wr_req_act_d  = 1'b1;
                  wr_data_act_d = word_ins;
                  word_d        = '0;
                  lane_cnt_d    = '0;
               end else begin
                  word_d     = word_ins;
                  lane_cnt_d = lane_nxt;
               end
               if (last_elem) begin
                  wr_req_flag_d  = 1'b1;
                  wr_data_flag_d = flags_nxt;
                  row_val_num_d  = nz_nxt;
                  flags_d        = '0;
                  nz_cnt_d       = '0;
                  elem_idx_d     = '0;
                  lane_cnt_d     = '0;
                  row_cnt_d      = row_cnt_inc;
                  if (row_cnt_inc == rows_q)
                     state_d = ST_DONE;
               end else begin
                  elem_idx_d = elem_idx_q + IDX_W'(1);
               end
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         rows_q         <= '0;
         row_cnt_q      <= '0;
         elem_idx_q     <= '0;
         lane_cnt_q     <= '0;
         word_q         <= '0;
         flags_q        <= '0;
         nz_cnt_q       <= '0;
         wr_req_act_q   <= 1'b0;
         wr_data_act_q  <= '0;
         wr_req_flag_q  <= 1'b0;
         wr_data_flag_q <= '0;
         row_val_num_q  <= '0;
      end else begin
         state_q        <= state_d;
         rows_q         <= rows_d;
         row_cnt_q      <= row_cnt_d;
         elem_idx_q     <= elem_idx_d;
         lane_cnt_q     <= lane_cnt_d;
         word_q         <= word_d;
         flags_q        <= flags_d;
         nz_cnt_q       <= nz_cnt_d;
         wr_req_act_q   <= wr_req_act_d;
         wr_data_act_q  <= wr_data_act_d;
         wr_req_flag_q  <= wr_req_flag_d;
         wr_data_flag_q <= wr_data_flag_d;
         row_val_num_q  <= row_val_num_d;
      end
   end

   // Entering DONE on the last row end lines done up with the final flag strobe.
   assign in_ready         = (state_q == ST_RUN);
   assign busy             = (state_q == ST_RUN);
   assign done             = (state_q == ST_DONE);
   assign wr_req_act       = wr_req_act_q;
   assign wr_data_act      = wr_data_act_q;
   assign wr_req_act_flag  = wr_req_flag_q;
   assign wr_data_act_flag = wr_data_flag_q;
   assign row_val_num      = row_val_num_q;

endmodule

// File: tb/tb_sparse_act_encoder.sv
// Directed bench for sparse_act_encoder: hand-computed words, flags and counts
// checked with immediate assertions.
module tb_sparse_act_encoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  num_rows;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_req_act_flag;
   logic [15:0] wr_data_act_flag;
   logic        wr_req_act;
   logic [23:0] wr_data_act;
   logic [4:0]  row_val_num;
   logic        busy;
   logic        done;

   sparse_act_encoder #(
      .DATA_WIDTH(8),
      .PACK(3),
      .ROW_LEN(16),
      .ROW_CNT_WIDTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .num_rows(num_rows),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .wr_req_act_flag(wr_req_act_flag),
      .wr_data_act_flag(wr_data_act_flag),
      .wr_req_act(wr_req_act),
      .wr_data_act(wr_data_act),
      .row_val_num(row_val_num),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [23:0] act_q[$];
   logic [15:0] flag_q[$];
   logic [4:0]  rvn_q[$];
   logic        fdone_q[$];
   int          done_cnt = 0;

   logic [7:0]  row_v [16];
   logic [23:0] exp_w[$];

   always @(negedge clk) begin
      if (wr_req_act) act_q.push_back(wr_data_act);
      if (wr_req_act_flag) begin
         flag_q.push_back(wr_data_act_flag);
         rvn_q.push_back(row_val_num);
         fdone_q.push_back(done);
      end
      if (done) done_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      act_q.delete(); flag_q.delete(); rvn_q.delete(); fdone_q.delete();
      done_cnt = 0;
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_start(input logic [7:0] n);
      start = 1'b1; num_rows = n;
      cycles(1);
      start = 1'b0;
   endtask

   // Feeds row_v[0..cnt-1]; gap inserts an idle in_valid=0 cycle after each element.
   task automatic send_row(input int cnt, input bit gap);
      for (int i = 0; i < cnt; i++) begin
         int t = 0;
         while (!in_ready && t < 20) begin cycles(1); t++; end
         if (t == 20) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
         in_valid = 1'b1; in_data = row_v[i];
         cycles(1);
         in_valid = 1'b0; in_data = '0;
         if (gap && i < cnt - 1) cycles(1);
      end
   endtask

   task automatic check_words(input string tag);
      chk({tag, "_nwords"}, act_q.size(), exp_w.size());
      for (int i = 0; i < exp_w.size() && i < act_q.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), {8'b0, act_q[i]}, {8'b0, exp_w[i]});
   endtask

   task automatic check_flag(input string tag, input int idx, input logic [15:0] f,
                             input logic [4:0] rvn, input logic d);
      if (idx < flag_q.size()) begin
         chk({tag, "_flag"}, {16'b0, flag_q[idx]}, {16'b0, f});
         chk({tag, "_rvn"},  {27'b0, rvn_q[idx]},  {27'b0, rvn});
         chk({tag, "_done"}, {31'b0, fdone_q[idx]}, {31'b0, d});
      end else begin
         chk({tag, "_flag_missing"}, flag_q.size(), idx + 1);
      end
   endtask

   task automatic load_test1();
      foreach (row_v[i]) row_v[i] = 8'h00;
      row_v[1] = 8'h05; row_v[4] = 8'h07; row_v[5] = 8'h09; row_v[7] = 8'h03;
      exp_w.delete(); exp_w.push_back(24'h050709); exp_w.push_back(24'h030000);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; start = 1'b0; num_rows = '0; in_valid = 1'b0; in_data = '0;
      cycles(3);
      chk("rst_busy",     {31'b0, busy},            32'd0);
      chk("rst_in_ready", {31'b0, in_ready},        32'd0);
      chk("rst_done",     {31'b0, done},            32'd0);
      chk("rst_req_act",  {31'b0, wr_req_act},      32'd0);
      chk("rst_req_flag", {31'b0, wr_req_act_flag}, 32'd0);
      reset = 1'b0;
      cycles(2);

      // Single row with a flushed partial word at row end.
      clear_log(); load_test1();
      do_start(8'd1);
      chk("t1_busy", {31'b0, busy}, 32'd1);
      send_row(16, 1'b0);
      cycles(3);
      check_words("t1");
      chk("t1_nflags", flag_q.size(), 32'd1);
      check_flag("t1", 0, 16'h4D00, 5'd4, 1'b1);
      chk("t1_done_cnt", done_cnt, 32'd1);
      chk("t1_idle_busy", {31'b0, busy}, 32'd0);

      // All-zero row, then 1..16, with a stray start during RUN.
      clear_log();
      do_start(8'd2);
      foreach (row_v[i]) row_v[i] = 8'h00;
      send_row(16, 1'b0);
      start = 1'b1; num_rows = 8'd5; cycles(1); start = 1'b0;
      for (int i = 0; i < 16; i++) row_v[i] = 8'(i + 1);
      send_row(16, 1'b0);
      cycles(3);
      exp_w.delete();
      exp_w.push_back(24'h010203); exp_w.push_back(24'h040506);
      exp_w.push_back(24'h070809); exp_w.push_back(24'h0A0B0C);
      exp_w.push_back(24'h0D0E0F); exp_w.push_back(24'h100000);
      check_words("t2");
      chk("t2_nflags", flag_q.size(), 32'd2);
      check_flag("t2r0", 0, 16'h0000, 5'd0,  1'b0);
      check_flag("t2r1", 1, 16'hFFFF, 5'd16, 1'b1);
      chk("t2_done_cnt", done_cnt, 32'd1);
      chk("t2_busy_after", {31'b0, busy}, 32'd0);

      // Exactly 2*PACK non-zeros: no padding word.
      clear_log();
      foreach (row_v[i]) row_v[i] = 8'h00;
      for (int i = 0; i < 6; i++) row_v[i] = 8'(i + 1);
      do_start(8'd1);
      send_row(16, 1'b0);
      cycles(3);
      exp_w.delete(); exp_w.push_back(24'h010203); exp_w.push_back(24'h040506);
      check_words("t3");
      check_flag("t3", 0, 16'hFC00, 5'd6, 1'b1);

      // Same as the first row, with in_valid toggling every cycle.
      clear_log(); load_test1();
      do_start(8'd1);
      send_row(16, 1'b1);
      cycles(3);
      check_words("t4");
      chk("t4_nflags", flag_q.size(), 32'd1);
      check_flag("t4", 0, 16'h4D00, 5'd4, 1'b1);

      // Reset mid-row must discard the partial word holding 0x08.
      clear_log();
      foreach (row_v[i]) row_v[i] = 8'h00;
      row_v[6] = 8'h08;
      do_start(8'd1);
      send_row(7, 1'b0);
      reset = 1'b1;
      cycles(1);
      chk("t5_rst_busy",     {31'b0, busy},             32'd0);
      chk("t5_rst_in_ready", {31'b0, in_ready},         32'd0);
      chk("t5_rst_req_act",  {31'b0, wr_req_act},       32'd0);
      chk("t5_rst_req_flag", {31'b0, wr_req_act_flag},  32'd0);
      chk("t5_rst_data_act", {8'b0, wr_data_act},       32'd0);
      chk("t5_rst_flagword", {16'b0, wr_data_act_flag}, 32'd0);
      chk("t5_rst_rvn",      {27'b0, row_val_num},      32'd0);
      chk("t5_rst_done",     {31'b0, done},             32'd0);
      reset = 1'b0;
      cycles(1);
      clear_log();
      foreach (row_v[i]) row_v[i] = 8'h00;
      row_v[15] = 8'h22;
      do_start(8'd1);
      send_row(16, 1'b0);
      cycles(3);
      exp_w.delete(); exp_w.push_back(24'h220000);
      check_words("t5");
      check_flag("t5", 0, 16'h0001, 5'd1, 1'b1);

      // num_rows=0: done one cycle after start, no strobes.
      clear_log();
      do_start(8'd0);
      chk("t6_done_pulse", {31'b0, done}, 32'd1);
      cycles(1);
      chk("t6_done_low", {31'b0, done}, 32'd0);
      cycles(2);
      chk("t6_nwords", act_q.size(), 32'd0);
      chk("t6_nflags", flag_q.size(), 32'd0);
      chk("t6_done_cnt", done_cnt, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
